mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences one CPU data-memory access (LB/LBU/LH/LHU/LW/SB/SH/SW) at a time between the
//  MEM stage and a data RAM that answers with a req/ack handshake.
//  - Byte-lane selection and byte-enable generation.
//  - Misalignment detection.
//  - Sign/zero extension of load data to 32 bits.
//  - MEM stage holds its request until req_ready, then waits for resp_valid.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in ACCESS before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  rst           in   1   synchronous, active-high reset
//  req_valid     in   1   MEM stage presents an access
//  req_ready     out  1   controller can accept; high only in IDLE
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1   1=zero-extend load (LBU/LHU), 0=sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  resp_valid    out  1   one-cycle pulse: access complete
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   valid with resp_valid: misaligned, reserved size or timeout
//  mem_en        out  1   RAM request, held until mem_ack
//  mem_we        out  4   byte enables, store only; 0000 for loads
//  mem_addr      out  32  {req_addr[31:2],2'b00}
//  mem_wdata     out  32  store data replicated to all lanes
//  mem_rdata     in   32  RAM read word, valid with mem_ack
//  mem_ack       in   1   RAM completion
// BEHAVIOUR
//  States: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP on error.
//  Reset values: state IDLE; req_ready 1; resp_valid 0; resp_err 0; resp_rdata 0.
//  Reset values: mem_en 0; mem_we 0; mem_addr 0; mem_wdata 0.
//  IDLE: accept on req_valid&&req_ready; latch we/size/unsigned/addr/wdata.
//  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11:
//    go to RESP with err=1; no RAM access.
//  - Otherwise go to ACCESS.
//  ACCESS: mem_en=1; mem_addr/mem_we/mem_wdata stable until ack.
//  - mem_we: byte -> 1<<addr[1:0]; half -> 0011<<addr[1:0]; word -> 1111.
//  - On mem_ack: capture mem_rdata, go to RESP, mem_en=0 next cycle.
//  RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in ACCESS and RESP.
//  Latency: ack in the first ACCESS cycle gives resp_valid 2 cycles after accept.
//  Error path: resp_valid 1 cycle after accept.
//  Load extension, little-endian:
//  - Byte = rdata[8*a+7:8*a], a=addr[1:0]; half = rdata[16*a1+15:16*a1], a1=addr[1].
//  - Sign-extend from bit 7/15 unless unsigned; word passes through.
//  mem_ack outside ACCESS is ignored. req_* inputs are ignored outside IDLE.
//  rst mid-access: state -> IDLE at that edge, mem_en=0; pending response is discarded.
//  Back-to-back: a new request is accepted the cycle after RESP.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//  - Counter cleared on entry to ACCESS, increments each ACCESS cycle without ack.
//  - At TIMEOUT_CYCLES: drop mem_en, go to RESP with err=1, rdata=0.
//  - A late ack is then ignored.
//  MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely; no counter logic.
// STRUCTURE
//  Shared package mem_ctrl_pkg: SIZE_BYTE/HALF/WORD/RSVD encodings; state encodings.
//  Sub-module load_extend: combinational lane select + sign/zero extend.
//  - Inputs: rdata, addr[1:0], size, unsigned. Output: 32-bit result.
// TESTING
//  - LB addr=0x..03, rdata=0x80xxxxxx, ack at first cycle -> resp_rdata=0xFFFFFF80, valid 2 cycles after accept.
//  - LHU addr=0x..02, rdata=0x8001xxxx -> resp_rdata=0x00008001; LH same -> 0xFFFF8001.
//  - SB addr=0x..01, wdata=0x000000AB -> mem_we=0010, mem_wdata=0xABABABAB, resp_rdata=0.
//  - LW addr=0x..02 -> resp_err=1 next cycle, mem_en never asserted; size=11 -> same.
//  - ack delayed 5 cycles -> mem_en/mem_addr stable 5 cycles; rst in cycle 3 -> IDLE, no resp_valid.
//  - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> resp_err=1 after 16 ACCESS cycles; late ack ignored.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
// Contents: access-size codes, FSM states, request check, lane helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Misaligned half/word or reserved size: never reaches the RAM.
    function automatic logic is_bad_req(input logic [1:0] size,
                                        input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = |off;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = 4'b0011 << off;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-justified store data copied to every lane it could land in.
    function automatic logic [31:0] lane_rep(input logic [1:0] size,
                                             input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            SIZE_BYTE: r = {4{wd[7:0]}};
            SIZE_HALF: r = {2{wd[15:0]}};
            default:   r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension to 32 bits (little-endian).
// Ports: i_rdata RAM word, i_addr byte offset, i_size, i_unsigned; o_result.
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_size)
            SIZE_BYTE: o_result = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_HALF: o_result = {{16{w_half[15] & ~i_unsigned}}, w_half};
            default:   o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// One-at-a-time CPU data access sequencer between MEM stage and a req/ack RAM.
// Ports: req_* from MEM stage, resp_* back to it, mem_* to the RAM.
// Optional abort of a stuck access: define MEM_TIMEOUT_EN (TIMEOUT_CYCLES).
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      r_state;
    state_e      w_next;
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        w_accept;
    logic        w_bad;
    logic        w_fin;
    logic        w_tmo;
    logic        w_err_nxt;
    logic [31:0] w_rdata_nxt;
    logic [31:0] w_ext;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_bad     = is_bad_req(req_size, req_addr[1:0]);
    assign w_fin     = (r_state == ST_ACCESS) && (mem_ack || w_tmo);

    load_extend u_ext (
        .i_rdata    (mem_rdata),
        .i_addr     (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_result   (w_ext)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_tmo_cnt <= '0;
        else if (w_accept)
            r_tmo_cnt <= '0;
        else if (r_state == ST_ACCESS && !mem_ack)
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end

    // Fires on the last allowed ACCESS cycle still lacking an ack.
    assign w_tmo = (r_state == ST_ACCESS) &&
                   (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_next    = ST_RESP;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack in the same cycle as the timeout still wins.
                if (mem_ack) begin
                    w_next = ST_RESP;
                    if (!r_we)
                        w_rdata_nxt = w_ext;
                end else if (w_tmo) begin
                    w_next    = ST_RESP;
                    w_err_nxt = 1'b1;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= SIZE_BYTE;
            r_off      <= '0;
        end else begin
            resp_valid <= (w_next == ST_RESP);
            resp_err   <= w_err_nxt;
            resp_rdata <= w_rdata_nxt;
            if (w_accept && !w_bad) begin
                r_we      <= req_we;
                r_uns     <= req_unsigned;
                r_size    <= req_size;
                r_off     <= req_addr[1:0];
                mem_en    <= 1'b1;
                mem_we    <= req_we ? byte_en(req_size, req_addr[1:0]) : 4'b0000;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wdata <= lane_rep(req_size, req_wdata);
            end else if (w_fin) begin
                mem_en <= 1'b0;
                mem_we <= 4'b0000;
            end
        end
    end

endmodule
